// File: rtl/logic_op_pipe.sv
// +----------------------------------------------------------------------------+
// | logic_op_pipe: selectable AND/OR/XOR/NAND on two operands, carried through |
// | a STAGES-deep valid/ready pipe with bubble collapse, zero flag, counter.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module logic_op_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_zero,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] result_cnt
);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic [WIDTH-1:0] op_res;
  logic [WIDTH-1:0] dat [STAGES];
  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] can_load;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    op_res = '0;
    case (op)
      OP_AND:  op_res = a & b;
      OP_OR:   op_res = a | b;
      OP_XOR:  op_res = a ^ b;
      OP_NAND: op_res = ~(a & b);
      default: op_res = '0;
    endcase
  end

  // Flattened ready chain: stage k can load unless it and every stage after it
  // are full while downstream is stalled.
  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic [WIDTH-1:0] data_q;
      logic             v_q;
      logic [WIDTH-1:0] d_in;
      logic             v_in;

      assign can_load[k] = out_ready | ~(&vld[STAGES-1:k]);

      if (k == 0) begin : g_first
        assign d_in = op_res;
        assign v_in = in_valid & can_load[0];
      end else begin : g_next
        assign d_in = dat[k-1];
        assign v_in = vld[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q    <= 1'b0;
          data_q <= '0;
        end else if (can_load[k]) begin
          v_q <= v_in;
          if (v_in) begin
            data_q <= d_in;
          end
        end
      end

      assign dat[k] = data_q;
      assign vld[k] = v_q;
    end
  endgenerate

  assign in_ready  = can_load[0];
  assign out_valid = vld[STAGES-1];
  assign q         = dat[STAGES-1];
  assign q_zero    = ~|dat[STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_valid && out_ready && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign result_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_op_pipe.sv
// Directed bench for logic_op_pipe with a queue scoreboard on the output port.
`default_nettype none

module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready, in_ready2;
  logic [7:0]  a, b;
  logic [1:0]  op;
  logic        out_valid, out_valid2;
  logic        out_ready;
  logic [7:0]  q, q2;
  logic        q_zero, q_zero2;
  logic        cnt_clr;
  logic [15:0] result_cnt;
  logic [1:0]  result_cnt2;

  int checks   = 0;
  int failures = 0;
  logic [7:0] sb [$];

  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .q_zero(q_zero), .cnt_clr(cnt_clr), .result_cnt(result_cnt)
  );

  logic_op_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .out_valid(out_valid2), .out_ready(out_ready),
    .q(q2), .q_zero(q_zero2), .cnt_clr(cnt_clr), .result_cnt(result_cnt2)
  );

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x & y);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    in_valid = 1'b1;
    a = x;
    b = y;
    op = o;
    step();
  endtask

  // Scoreboard: output handshake pops first, then an input handshake pushes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        assert (sb.size() != 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%0h expected=none", q);
        end
        if (sb.size() != 0) begin
          logic [7:0] e;
          e = sb.pop_front();
          chk("sb_q", q, e);
          chk("sb_qzero", q_zero, (e == 8'h00));
        end
      end
      if (in_valid && in_ready) sb.push_back(model(a, b, op));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; op = '0;
    out_ready = 1'b1; cnt_clr = 1'b0;
    step(); step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_q", q, 8'h00);
    chk("rst_q_zero", q_zero, 1'b1);
    chk("rst_cnt", result_cnt, 16'd0);
    rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1'b1);

    // Latency: visible two cycles after acceptance, counted one cycle later.
    send(8'hF0, 8'h3C, 2'b00);
    in_valid = 1'b0;
    chk("lat_early", out_valid, 1'b0);
    step();
    chk("lat_valid", out_valid, 1'b1);
    chk("lat_q", q, 8'h30);
    chk("lat_qzero", q_zero, 1'b0);
    step();
    chk("lat_cnt", result_cnt, 16'd1);

    // All four ops back to back.
    for (int i = 0; i < 4; i++) begin
      chk("ops_in_ready", in_ready, 1'b1);
      send(8'hF0, 8'h3C, 2'(i));
    end
    in_valid = 1'b0;
    chk("ops_valid_c4", out_valid, 1'b1);
    chk("ops_q_c4", q, 8'hCC);
    step();
    chk("ops_valid_c5", out_valid, 1'b1);
    chk("ops_q_c5", q, 8'hCF);
    step();
    chk("ops_drained", out_valid, 1'b0);
    chk("ops_q_hold", q, 8'hCF);

    // Backpressure: only two fit while stalled, then a gapless drain.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("bp_cnt_clr", result_cnt, 16'd0);
    out_ready = 1'b0;
    send(8'h12, 8'h34, 2'b01);
    send(8'h56, 8'h78, 2'b10);
    chk("bp_full", in_ready, 1'b0);
    chk("bp_q_hold", q, 8'h36);
    chk("bp_valid_hold", out_valid, 1'b1);
    out_ready = 1'b1;
    chk("bp_valid_r0", out_valid, 1'b1);
    send(8'h9A, 8'hBC, 2'b11);
    chk("bp_valid_r1", out_valid, 1'b1);
    send(8'hDE, 8'hF0, 2'b00);
    chk("bp_valid_r2", out_valid, 1'b1);
    send(8'h0F, 8'h33, 2'b10);
    in_valid = 1'b0;
    chk("bp_valid_r3", out_valid, 1'b1);
    step();
    chk("bp_valid_r4", out_valid, 1'b1);
    step();
    chk("bp_drained", out_valid, 1'b0);
    chk("bp_cnt", result_cnt, 16'd5);

    // Zero flag with a bubble ahead and downstream stalled.
    out_ready = 1'b0;
    step();
    send(8'h0F, 8'hF0, 2'b00);
    in_valid = 1'b0;
    step();
    chk("zero_valid", out_valid, 1'b1);
    chk("zero_q", q, 8'h00);
    chk("zero_flag", q_zero, 1'b1);
    out_ready = 1'b1;
    step();
    chk("zero_drained", out_valid, 1'b0);

    // Saturation on the 2-bit counter instance.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("sat_clr", result_cnt2, 2'd0);
    for (int i = 0; i < 5; i++) begin
      send(8'(8'h11 * i + 1), 8'hA5, 2'b10);
      in_valid = 1'b0;
      step();
      step();
      chk("sat_cnt", result_cnt2, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    send(8'hFF, 8'h01, 2'b00);
    in_valid = 1'b0;
    step();
    chk("clr_hs_valid", out_valid, 1'b1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    chk("clr_hs_cnt2", result_cnt2, 2'd0);
    chk("clr_hs_cnt", result_cnt, 16'd0);

    // Asynchronous reset with two results in flight.
    out_ready = 1'b0;
    send(8'hAA, 8'h55, 2'b01);
    send(8'hC3, 8'h3C, 2'b11);
    in_valid = 1'b0;
    chk("mid_full", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("mid_out_valid", out_valid, 1'b0);
    chk("mid_q", q, 8'h00);
    chk("mid_q_zero", q_zero, 1'b1);
    chk("mid_cnt", result_cnt, 16'd0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("mid_no_stale", out_valid, 1'b0);
    end

    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
